// File: rtl/sseg_scan_driver.sv
// ============================================================================
// Module   : sseg_scan_driver
// Purpose  : Time-multiplexed, double-buffered hex driver for a common-anode
//            seven-segment bank. Optional macro: SSEG_LEADING_ZERO_BLANK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_wrap;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_disp_dp;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_en;
  logic                    w_blank;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_tick     = (r_cnt == c_cnt_last);
  assign w_boundary = w_tick && (r_idx == c_idx_last);

  // Digit selection by comparison keeps NUM_DIGITS=1 free of out-of-range indexing.
  always_comb begin
    w_nib = 4'h0;
    w_dp  = 1'b0;
    w_en  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib = r_disp[4*i +: 4];
        w_dp  = r_disp_dp[i];
        w_en  = digit_en[i];
      end
    end
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] w_msnz;

  // Highest non-zero nibble; stays 0 for an all-zero value so digit 0 always shows.
  always_comb begin
    w_msnz = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_disp[4*i +: 4] != 4'h0) begin
        w_msnz = IDX_W'(i);
      end
    end
  end

  assign w_blank = (r_idx > w_msnz);
`else
  assign w_blank = 1'b0;
`endif

  assign w_lit    = w_en && !w_blank;
  assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx);

  // Refresh timing and digit scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wrap      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end
      // Delayed one extra cycle so the pulse lines up with digit 0 on the pins.
      r_wrap      <= w_boundary;
      frame_start <= r_wrap;
    end
  end

  // Double buffer: display only changes on a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
    end else if (w_boundary) begin
      if (load) begin
        r_disp      <= value;
        r_disp_dp   <= dp_in;
        r_pend_flag <= 1'b0;
      end else if (r_pend_flag) begin
        r_disp      <= r_pend;
        r_disp_dp   <= r_pend_dp;
        r_pend_flag <= 1'b0;
      end
    end else if (load) begin
      r_pend      <= value;
      r_pend_dp   <= dp_in;
      r_pend_flag <= 1'b1;
    end
  end

  // Pin registers; a dark digit also forces every segment off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= w_lit ? w_an_sel : '1;
      sseg <= w_lit ? {~w_dp, glyph(w_nib)} : 8'hFF;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver: 4-digit instance against a frame-level model,
// plus a 1-digit instance checked against its fixed scan pattern.
`timescale 1ns/1ps
`default_nettype none

module tb_sseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int P  = ND * RD;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value    = 16'h0;
  logic [3:0]  dp_in    = 4'h0;
  logic [3:0]  digit_en = 4'hF;

  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;
  logic [0:0]  an1;
  logic [7:0]  sseg1;
  logic        fs1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .an(an), .sseg(sseg), .frame_start(frame_start)
  );

  sseg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .load(1'b0), .value(4'h0), .dp_in(1'b0),
    .digit_en(1'b1), .an(an1), .sseg(sseg1), .frame_start(fs1)
  );

  // Reference model: time is counted in clock edges since reset release.
  logic [7:0]  glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          m_e    = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_pdp  = 4'h0;
  logic        m_flag = 1'b0;
  logic [3:0]  x_an   = 4'hF;
  logic [7:0]  x_sseg = 8'hFF;
  logic        x_fs   = 1'b0;

  function automatic logic [11:0] ref_out(input int e, input logic [15:0] disp,
                                          input logic [3:0] dp, input logic [3:0] en);
    int         idx;
    int         top;
    logic [3:0] nib;
    logic       lit;
    idx = (e / RD) % ND;
    nib = 4'((disp >> (4 * idx)) & 16'hF);
    top = 0;
    for (int i = 0; i < ND; i++)
      if (((disp >> (4 * i)) & 16'hF) != 0) top = i;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    lit = en[idx] && (idx <= top);
`else
    lit = en[idx];
`endif
    if (!lit) return {4'hF, 8'hFF};
    return {~(4'b0001 << idx), ~dp[idx], glyph_tab[nib][6:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e    <= 0;
      m_disp <= 16'h0;
      m_pend <= 16'h0;
      m_dp   <= 4'h0;
      m_pdp  <= 4'h0;
      m_flag <= 1'b0;
      x_an   <= 4'hF;
      x_sseg <= 8'hFF;
      x_fs   <= 1'b0;
    end else begin
      {x_an, x_sseg} <= ref_out(m_e, m_disp, m_dp, digit_en);
      x_fs <= (m_e >= 1) && (m_e % P == 0);
      if ((m_e + 1) % P == 0) begin
        if (load) begin
          m_disp <= value;
          m_dp   <= dp_in;
          m_flag <= 1'b0;
        end else if (m_flag) begin
          m_disp <= m_pend;
          m_dp   <= m_pdp;
          m_flag <= 1'b0;
        end
      end else if (load) begin
        m_pend <= value;
        m_pdp  <= dp_in;
        m_flag <= 1'b1;
      end
      m_e <= m_e + 1;
    end
  end

  task automatic check(input string tag);
    logic       x1_an;
    logic [7:0] x1_sseg;
    logic       x1_fs;
    x1_an   = (m_e >= 1) ? 1'b0 : 1'b1;
    x1_sseg = (m_e >= 1) ? 8'hC0 : 8'hFF;
    x1_fs   = (m_e >= 2) && ((m_e - 1) % 2 == 0);
    checks++;
    assert (an === x_an) else begin
      failures++; $error("FAIL %s an got %h want %h (edge %0d)", tag, an, x_an, m_e);
    end
    checks++;
    assert (sseg === x_sseg) else begin
      failures++; $error("FAIL %s sseg got %h want %h (edge %0d)", tag, sseg, x_sseg, m_e);
    end
    checks++;
    assert (frame_start === x_fs) else begin
      failures++; $error("FAIL %s frame_start got %b want %b (edge %0d)", tag, frame_start, x_fs, m_e);
    end
    checks++;
    assert (an1 === x1_an) else begin
      failures++; $error("FAIL %s nd1_an got %b want %b (edge %0d)", tag, an1, x1_an, m_e);
    end
    checks++;
    assert (sseg1 === x1_sseg) else begin
      failures++; $error("FAIL %s nd1_sseg got %h want %h (edge %0d)", tag, sseg1, x1_sseg, m_e);
    end
    checks++;
    assert (fs1 === x1_fs) else begin
      failures++; $error("FAIL %s nd1_frame_start got %b want %b (edge %0d)", tag, fs1, x1_fs, m_e);
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) tick(tag);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input string tag);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick(tag);
    load  = 1'b0;
  endtask

  // Advance until the edge count within the frame reaches the given phase.
  task automatic align(input int phase, input string tag);
    for (int i = 0; i < 2 * P && (m_e % P) != phase; i++) tick(tag);
  endtask

  initial begin
    #1 rst = 1'b1;
    run(3, "reset");
    rst = 1'b0;
    run(2, "post_reset");

    do_load(16'h1A3F, 4'h0, "load_1a3f");
    run(2 * P, "frame_1a3f");

    align(2, "align_dbl");
    do_load(16'h0000, 4'h0, "load_0000");
    run(3, "mid_frame");
    do_load(16'h5555, 4'h0, "load_5555");
    run(2 * P, "frame_5555");

    align(P - 1, "align_bypass");
    do_load(16'h9C2E, 4'b1010, "load_bypass");
    run(P + 2, "frame_bypass");

    digit_en = 4'b0101;
    do_load(16'h8888, 4'b0001, "load_8888");
    run(2 * P, "frame_8888");
    digit_en = 4'hF;

    do_load(16'h00B0, 4'h0, "load_00b0");
    run(2 * P, "frame_00b0");
    do_load(16'h0000, 4'hF, "load_zero");
    run(2 * P, "frame_zero");
    do_load(16'h0D47, 4'b0110, "load_0d47");
    run(2 * P, "frame_0d47");

    align(2 * RD + 1, "align_rst");
    rst = 1'b1;
    #1 check("rst_async");
    run(3, "in_reset");
    rst = 1'b0;
    run(2 * P, "after_rst");

    for (int n = 0; n < 60; n++) begin
      digit_en = 4'($urandom);
      if ($urandom_range(0, 2) == 0)
        do_load(16'($urandom), 4'($urandom), "rand_load");
      run($urandom_range(1, 6), "rand_run");
    end
    run(2 * P, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
